mem_interface: RTL and testbench

Memory-side stage of the SRC CPU bus. It consumes the `R`/`W` access strobes held by the clocking logic and runs a req/ack handshake to external memory. It returns `Wait` while the access is outstanding and a one-cycle `Done` when it completes, and it holds captured read data in a memory-data register for the datapath.

---
 rtl/src_pkg.sv | 12 +
 rtl/wait_timer.sv | 21 ++
 rtl/mem_interface.sv | 120 ++++++++++++
 tb/tb_mem_interface.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/src_pkg.sv
// Shared types for the SRC CPU memory-side stage.
// States of the bus handshake FSM and default bus widths.
package src_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    HOLD
  } mem_state_t;
endpackage

// File: rtl/wait_timer.sv
// Bounded wait counter for an outstanding memory request.
// Used only when MEM_TIMEOUT_EN is defined.
module wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);
  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) cnt <= '0;
    else if (en) cnt <= cnt + 8'd1;
  end

  // fires on the TIMEOUT-th un-acked cycle, before the count wraps
  assign expired = en && (cnt == 8'(TIMEOUT - 1));
endmodule

// File: rtl/mem_interface.sv
// Memory-side stage: R/W strobes to a req/ack memory handshake.
// Optional request timeout under `define MEM_TIMEOUT_EN.
module mem_interface
  import src_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              R,
  input  logic              W,
  input  logic [ADDR_W-1:0] ma,
  input  logic [DATA_W-1:0] md_in,
  output logic              Wait,
  output logic              Done,
  output logic [DATA_W-1:0] md_out,
  output logic              bus_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);
  mem_state_t        state, state_n;
  logic              wait_n, done_n, err_n;
  logic              req_n, we_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] wdata_n, md_n;
  logic              expired;

`ifdef MEM_TIMEOUT_EN
  wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (state == IDLE),
    .en     ((state == BUSY) && !mem_ack),
    .expired(expired)
  );
`else
  assign expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      Wait      <= 1'b0;
      Done      <= 1'b0;
      bus_err   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      md_out    <= '0;
    end else begin
      state     <= state_n;
      Wait      <= wait_n;
      Done      <= done_n;
      bus_err   <= err_n;
      mem_req   <= req_n;
      mem_we    <= we_n;
      mem_addr  <= addr_n;
      mem_wdata <= wdata_n;
      md_out    <= md_n;
    end
  end

  always_comb begin
    state_n = state;
    wait_n  = Wait;
    done_n  = 1'b0;
    err_n   = bus_err;
    req_n   = mem_req;
    we_n    = mem_we;
    addr_n  = mem_addr;
    wdata_n = mem_wdata;
    md_n    = md_out;
    unique case (state)
      IDLE: begin
        if (R || W) begin
          addr_n  = ma;
          wdata_n = md_in;
          we_n    = W & ~R;
          err_n   = 1'b0;
          if (R && W) begin
            done_n  = 1'b1;
            err_n   = 1'b1;
            state_n = HOLD;
          end else begin
            req_n   = 1'b1;
            wait_n  = 1'b1;
            state_n = BUSY;
          end
        end
      end
      BUSY: begin
        if (mem_ack) begin
          req_n   = 1'b0;
          wait_n  = 1'b0;
          done_n  = 1'b1;
          state_n = HOLD;
          if (!mem_we) md_n = mem_rdata;
        end else if (expired) begin
          req_n   = 1'b0;
          wait_n  = 1'b0;
          done_n  = 1'b1;
          err_n   = 1'b1;
          state_n = HOLD;
        end
      end
      HOLD: begin
        // the strobe is still held after Done; wait for it to drop
        if (!(R || W)) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mem_interface.sv
// Directed bench for mem_interface with a scoreboard of completions.
// Timeout cases run only when MEM_TIMEOUT_EN is defined.
module tb_mem_interface;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        R = 1'b0, W = 1'b0;
  logic [31:0] ma = '0, md_in = '0;
  logic        Wait, Done, bus_err, mem_req, mem_we;
  logic [31:0] md_out, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  typedef struct packed {
    logic [31:0] md;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] model_md = '0;

  always #5 clk = ~clk;

  mem_interface #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .R        (R),
    .W        (W),
    .ma       (ma),
    .md_in    (md_in),
    .Wait     (Wait),
    .Done     (Done),
    .md_out   (md_out),
    .bus_err  (bus_err),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_wait"}, 32'(Wait), 32'd0);
    chk({tag, "_done"}, 32'(Done), 32'd0);
    chk({tag, "_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_err"}, 32'(bus_err), 32'd0);
    chk({tag, "_addr"}, mem_addr, 32'd0);
    chk({tag, "_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_md"}, md_out, 32'd0);
  endtask

  // dly: un-acked req cycles before ack (-1 = never ack)
  task automatic access(input string tag, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] rd, input int dly,
                        input int exp_lat, input int hold);
    int   cyc, waited, wcnt;
    logic rw_err, acked;
    exp_t e, got;
    rw_err = r & w;
    acked  = !rw_err && dly >= 0 && (dly < 4 || dly < 1000);
`ifdef MEM_TIMEOUT_EN
    if (dly < 0 || dly >= 4) acked = 1'b0;
`else
    if (dly < 0) acked = 1'b0;
`endif
    e.err = rw_err | (!rw_err && !acked);
    if (acked && r && !w) model_md = rd;
    e.md = model_md;
    sb.push_back(e);
    R = r; W = w; ma = a; md_in = d;
    step();
    cyc = 1; waited = 0; wcnt = 0;
    while (!Done && cyc < 40) begin
      if (Wait) wcnt++;
      if (mem_req) begin
        if (mem_addr !== a || mem_wdata !== d || mem_we !== (w & ~r)) begin
          chk({tag, "_busy_stable"}, {mem_addr[15:0], mem_wdata[15:0]},
              {a[15:0], d[15:0]});
        end
        if (waited == dly) begin
          mem_ack = 1'b1;
          mem_rdata = rd;
        end
        waited++;
      end
      step();
      mem_ack = 1'b0;
      cyc++;
    end
    chk({tag, "_done"}, 32'(Done), 32'd1);
    chk({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
    chk({tag, "_wait_lo"}, 32'(Wait), 32'd0);
    chk({tag, "_req_lo"}, 32'(mem_req), 32'd0);
    if (!rw_err) chk({tag, "_we"}, 32'(mem_we), 32'(w));
    if (!rw_err) chk({tag, "_wait_cycles"}, 32'(wcnt), 32'(exp_lat - 1));
    if (sb.size() != 0) begin
      got = sb.pop_front();
      chk({tag, "_md_out"}, md_out, got.md);
      chk({tag, "_bus_err"}, 32'(bus_err), 32'(got.err));
    end
    step();
    chk({tag, "_done_pulse"}, 32'(Done), 32'd0);
    for (int i = 0; i < hold; i++) begin
      step();
      chk({tag, "_hold_req"}, 32'(mem_req | Done | Wait), 32'd0);
    end
    R = 1'b0; W = 1'b0;
    step();
  endtask

  always @(posedge clk) begin
    if (!rst && Wait && Done) begin
      total++;
      bad++;
      $error("FAIL wait_done_overlap observed=1 expected=0");
    end
  end

  initial begin
    step();
    step();
    chk_idle_outs("reset");
    rst = 1'b0;
    step();
    chk("idle_req", 32'(mem_req), 32'd0);

    access("rd0", 1'b1, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 2, 2);
    access("wr3", 1'b0, 1'b1, 32'h200, 32'h1234, 32'h0BAD0BAD, 3, 5, 0);
    access("rw", 1'b1, 1'b1, 32'h240, 32'h77, 32'h0, 0, 1, 0);
    access("rd2", 1'b1, 1'b0, 32'h280, 32'h0, 32'h13572468, 2, 4, 1);

    W = 1'b1; ma = 32'h300; md_in = 32'h55;
    step();
    chk("mid_req", 32'(mem_req), 32'd1);
    rst = 1'b1; W = 1'b0;
    step();
    chk_idle_outs("mid_rst");
    rst = 1'b0;
    step();
    chk("post_rst_done", 32'(Done), 32'd0);
    model_md = '0;
    access("rd_after", 1'b1, 1'b0, 32'h400, 32'h0, 32'hCAFEF00D, 1, 3, 0);

`ifdef MEM_TIMEOUT_EN
    access("tmo", 1'b1, 1'b0, 32'h500, 32'h0, 32'h11111111, -1, 5, 0);
    access("tmo_ack", 1'b1, 1'b0, 32'h540, 32'h0, 32'h22222222, 3, 5, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
